stream_merge2: RTL and testbench

//  Merges two byte streams (valid/ready, last-flagged packets) into one output stream toward the checker.

---
 rtl/stream_merge2_pkg.sv | 12 +
 rtl/stream_merge2_rr_arb2.sv | 18 +
 rtl/stream_merge2.sv | 110 +++++++++++
 tb/tb_stream_merge2.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/stream_merge2_pkg.sv
// Shared types for the two-source byte stream merger.
package stream_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOCK0,
      LOCK1
   } merge_state_t;

endpackage

// File: rtl/stream_merge2_rr_arb2.sv
// Two-way round-robin arbiter: a tie goes to the source that did not win last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end

endmodule

// File: rtl/stream_merge2.sv
// Merges two last-flagged byte streams into one, tagging each byte with its source.
// Packets are locked to one source until last or truncation at MAX_PKT_LEN bytes.
module stream_merge2
   import stream_pkg::*;
#(
   parameter int DATA_W      = BYTE_W,
   parameter int MAX_PKT_LEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        in_valid,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [1:0]        in_last,
   output logic [1:0]        in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sel,
   output logic              out_last,
   input  logic              out_ready,
   output logic              pkt_trunc
);

   localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
   localparam logic [CNT_W-1:0] TRUNC_AT = CNT_W'(MAX_PKT_LEN - 1);

   merge_state_t      state, state_nxt;
   logic              last_grant, last_grant_nxt;
   logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
   logic [1:0]        arb_gnt;
   logic [1:0]        grant;
   logic              can_take;
   logic              take;
   logic              sel;
   logic              take_last;
   logic              trunc;
   logic [DATA_W-1:0] take_data;

   rr_arb2 u_arb (
      .req        (in_valid),
      .last_grant (last_grant),
      .gnt        (arb_gnt)
   );

   // Grant depends only on state, last_grant and in_valid, never on out_ready.
   always_comb begin
      case (state)
         LOCK0:   grant = 2'b01;
         LOCK1:   grant = 2'b10;
         default: grant = arb_gnt;
      endcase
   end

   always_comb begin
      can_take  = !out_valid || out_ready;
      in_ready  = grant & {2{can_take && rst_n}};
      take      = |(in_valid & in_ready);
      sel       = grant[1];
      take_last = sel ? in_last[1] : in_last[0];
      take_data = sel ? in_data1 : in_data0;
      trunc     = take && !take_last && (byte_cnt == TRUNC_AT);

      state_nxt      = state;
      last_grant_nxt = last_grant;
      byte_cnt_nxt   = byte_cnt;
      if (take) begin
         if (state == IDLE) last_grant_nxt = sel;
         if (take_last || trunc) begin
            state_nxt    = IDLE;
            byte_cnt_nxt = '0;
         end else if (state == IDLE) begin
            state_nxt    = sel ? LOCK1 : LOCK0;
            byte_cnt_nxt = CNT_W'(1);
         end else begin
            byte_cnt_nxt = byte_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         byte_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         byte_cnt   <= byte_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 1'b0;
         out_last  <= 1'b0;
         pkt_trunc <= 1'b0;
      end else begin
         pkt_trunc <= trunc;
         if (can_take) out_valid <= take;
         if (take) begin
            out_data <= take_data;
            out_sel  <= sel;
            out_last <= take_last || trunc;
         end
      end
   end

endmodule

// File: tb/tb_stream_merge2.sv
// Directed scoreboard bench for stream_merge2 (MAX_PKT_LEN=4).
module tb_stream_merge2;

   logic       clk;
   logic       rst_n;
   logic [1:0] in_valid;
   logic [7:0] in_data0;
   logic [7:0] in_data1;
   logic [1:0] in_last;
   logic [1:0] in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sel;
   logic       out_last;
   logic       out_ready;
   logic       pkt_trunc;

   typedef struct {
      logic       sel;
      logic [7:0] data;
      logic       last;
      logic       trunc;
      logic       seen;
   } item_t;

   item_t q[$];
   int n_tests = 0;
   int n_fail  = 0;

   stream_merge2 #(.DATA_W(8), .MAX_PKT_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last),
      .out_ready (out_ready),
      .pkt_trunc (pkt_trunc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      logic exp_tr;
      chk({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0 && out_valid) begin
         exp_tr = q[0].trunc && !q[0].seen;
         q[0].seen = 1'b1;
         chk({tag, " out_data"},  {24'b0, out_data},  {24'b0, q[0].data});
         chk({tag, " out_sel"},   {31'b0, out_sel},   {31'b0, q[0].sel});
         chk({tag, " out_last"},  {31'b0, out_last},  {31'b0, q[0].last});
         chk({tag, " pkt_trunc"}, {31'b0, pkt_trunc}, {31'b0, exp_tr});
         if (out_ready) void'(q.pop_front());
      end else begin
         chk({tag, " pkt_trunc idle"}, {31'b0, pkt_trunc}, 32'd0);
      end
   endtask

   task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] l, input logic ordy, input logic [1:0] exp_rdy,
                       input logic exp_tr, input string tag);
      item_t it;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data0  = d0;
      in_data1  = d1;
      in_last   = l;
      out_ready = ordy;
      @(negedge clk);
      check_out(tag);
      chk({tag, " in_ready"}, {30'b0, in_ready}, {30'b0, exp_rdy});
      if (|(v & exp_rdy)) begin
         it.sel   = exp_rdy[1];
         it.data  = exp_rdy[1] ? d1 : d0;
         it.last  = (exp_rdy[1] ? l[1] : l[0]) | exp_tr;
         it.trunc = exp_tr;
         it.seen  = 1'b0;
         q.push_back(it);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, " out_data"},  {24'b0, out_data},  32'd0);
      chk({tag, " out_sel"},   {31'b0, out_sel},   32'd0);
      chk({tag, " out_last"},  {31'b0, out_last},  32'd0);
      chk({tag, " pkt_trunc"}, {31'b0, pkt_trunc}, 32'd0);
      chk({tag, " in_ready"},  {30'b0, in_ready},  32'd0);
   endtask

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data0  = '0;
      in_data1  = '0;
      in_last   = '0;
      out_ready = 1'b1;
      #12;
      chk_reset("reset");
      rst_n = 1'b1;

      // tie after reset: source 0 first, then alternate
      step(2'b11, 8'hA0, 8'hB0, 2'b11, 1'b1, 2'b01, 1'b0, "tie0");
      step(2'b11, 8'hA0, 8'hB0, 2'b11, 1'b1, 2'b10, 1'b0, "tie1");
      step(2'b11, 8'hA0, 8'hB0, 2'b11, 1'b1, 2'b01, 1'b0, "tie2");
      step(2'b11, 8'hA0, 8'hB0, 2'b11, 1'b1, 2'b10, 1'b0, "tie3");
      step(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, "tie_drain");

      // single source 3-byte packet
      step(2'b01, 8'h41, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, "single0");
      step(2'b01, 8'h42, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, "single1");
      step(2'b01, 8'h43, 8'h00, 2'b01, 1'b1, 2'b01, 1'b0, "single2");
      step(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, "single_drain");

      // packet lock: src1 waits for src0's last
      step(2'b01, 8'h61, 8'h71, 2'b00, 1'b1, 2'b01, 1'b0, "lock0");
      step(2'b11, 8'h62, 8'h71, 2'b10, 1'b1, 2'b01, 1'b0, "lock1");
      step(2'b11, 8'h63, 8'h71, 2'b11, 1'b1, 2'b01, 1'b0, "lock2");
      step(2'b10, 8'h00, 8'h71, 2'b10, 1'b1, 2'b10, 1'b0, "lock3");
      step(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, "lock_drain");

      // backpressure mid-packet
      step(2'b01, 8'h51, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, "bp0");
      step(2'b01, 8'h52, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, "bp1");
      for (int unsigned i = 0; i < 4; i++)
         step(2'b01, 8'h53, 8'h00, 2'b01, 1'b0, 2'b00, 1'b0, "bp_stall");
      step(2'b01, 8'h53, 8'h00, 2'b01, 1'b1, 2'b01, 1'b0, "bp2");
      step(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, "bp_drain");

      // truncation at 4 bytes, remainder forms a new packet
      step(2'b10, 8'h00, 8'h81, 2'b00, 1'b1, 2'b10, 1'b0, "trunc1");
      step(2'b10, 8'h00, 8'h82, 2'b00, 1'b1, 2'b10, 1'b0, "trunc2");
      step(2'b10, 8'h00, 8'h83, 2'b00, 1'b1, 2'b10, 1'b0, "trunc3");
      step(2'b10, 8'h00, 8'h84, 2'b00, 1'b1, 2'b10, 1'b1, "trunc4");
      step(2'b10, 8'h00, 8'h85, 2'b00, 1'b1, 2'b10, 1'b0, "trunc5");
      step(2'b10, 8'h00, 8'h86, 2'b10, 1'b1, 2'b10, 1'b0, "trunc6");
      step(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, "trunc_drain");

      // async reset mid-packet, then tie must go to src0 again
      step(2'b01, 8'h91, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, "rst_pkt0");
      step(2'b01, 8'h92, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, "rst_pkt1");
      @(posedge clk);
      #3;
      rst_n    = 1'b0;
      in_valid = '0;
      in_last  = '0;
      #1;
      chk_reset("midreset");
      q.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      step(2'b11, 8'hC0, 8'hD0, 2'b11, 1'b1, 2'b01, 1'b0, "post_tie0");
      step(2'b11, 8'hC0, 8'hD0, 2'b11, 1'b1, 2'b10, 1'b0, "post_tie1");
      step(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, "post_drain");
      step(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, "post_empty");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
